// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator-feed ALU: default widths, opcodes, FSM states.
package alu_pkg;

    localparam int NBITS_D_DEF  = 16;
    localparam int NBITS_OP_DEF = 3;

    localparam logic [NBITS_OP_DEF-1:0] OP_LDB = 3'b000;
    localparam logic [NBITS_OP_DEF-1:0] OP_ADD = 3'b001;
    localparam logic [NBITS_OP_DEF-1:0] OP_SUB = 3'b010;
    localparam logic [NBITS_OP_DEF-1:0] OP_AND = 3'b011;
    localparam logic [NBITS_OP_DEF-1:0] OP_OR  = 3'b100;
    localparam logic [NBITS_OP_DEF-1:0] OP_XOR = 3'b101;
    localparam logic [NBITS_OP_DEF-1:0] OP_MUL = 3'b110;
    localparam logic [NBITS_OP_DEF-1:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per i_step, fixed NBITS_D steps.
module alu_shift_add_mul #(
    parameter int NBITS_D = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_load,
    input  logic                   i_step,
    input  logic [NBITS_D-1:0]     i_a,
    input  logic [NBITS_D-1:0]     i_b,
    output logic                   o_last,
    output logic [2*NBITS_D-1:0]   o_product
);

    localparam int CW = $clog2(NBITS_D + 1);

    logic [2*NBITS_D-1:0] mcand_q, mcand_d;
    logic [NBITS_D-1:0]   mplier_q, mplier_d;
    logic [2*NBITS_D-1:0] product_q, product_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*NBITS_D-1:0] product_next;

    // Product after this cycle's partial add; exposed so the caller can capture the
    // final value on the same edge as the last step.
    always_comb begin
        product_next = product_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        product_d    = product_q;
        count_d      = count_q;
        if (i_load) begin
            mcand_d   = {{NBITS_D{1'b0}}, i_a};
            mplier_d  = i_b;
            product_d = '0;
            count_d   = CW'(NBITS_D);
        end else if (i_step) begin
            product_d = product_next;
            mcand_d   = mcand_q << 1;
            mplier_d  = mplier_q >> 1;
            count_d   = count_q - CW'(1);
        end
    end

    assign o_last    = (count_q == CW'(1));
    assign o_product = product_next;

    // Step counter: reset so a stale count can never signal o_last after an abort.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Datapath registers.
    // NOTE: no reset here on purpose; every multiply reloads them via i_load before use.
    always_ff @(posedge i_clk) begin
        mcand_q   <= mcand_d;
        mplier_q  <= mplier_d;
        product_q <= product_d;
    end

endmodule

// File: rtl/alu_seq_acc_feed.sv
// ALU stage feeding the accumulator: single-cycle ops plus an iterative MUL, registered
// result/flags and a one-cycle write strobe for the accumulator.
module alu_seq_acc_feed
    import alu_pkg::*;
#(
    parameter int NBITS_D  = NBITS_D_DEF,
    parameter int NBITS_OP = NBITS_OP_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NBITS_OP-1:0] i_op,
    input  logic [NBITS_D-1:0]  i_A,
    input  logic [NBITS_D-1:0]  i_B,
    output logic [NBITS_D-1:0]  o_result,
    output logic                o_WrAcc,
    output logic                o_busy,
    output logic                o_zero,
    output logic                o_carry
);

    state_e               state_q, state_d;
    logic [NBITS_D-1:0]   result_q, result_d;
    logic                 wr_acc_q, wr_acc_d;
    logic                 busy_q, busy_d;
    logic                 zero_q, zero_d;
    logic                 carry_q, carry_d;

    logic                 mul_load, mul_step, mul_last;
    logic [2*NBITS_D-1:0] mul_product;

    logic [NBITS_D:0]     sum_w, diff_w;
    logic [NBITS_D-1:0]   alu_res;
    logic                 alu_carry;

    alu_shift_add_mul #(.NBITS_D(NBITS_D)) u_mul (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (mul_load),
        .i_step    (mul_step),
        .i_a       (i_A),
        .i_b       (i_B),
        .o_last    (mul_last),
        .o_product (mul_product)
    );

    // Single-cycle operations on the live operands; carry/borrow comes from the extra bit.
    always_comb begin
        sum_w     = {1'b0, i_A} + {1'b0, i_B};
        diff_w    = {1'b0, i_A} - {1'b0, i_B};
        alu_res   = i_A;
        alu_carry = 1'b0;
        case (i_op)
            OP_LDB: alu_res = i_B;
            OP_ADD: begin alu_res = sum_w[NBITS_D-1:0];  alu_carry = sum_w[NBITS_D];  end
            OP_SUB: begin alu_res = diff_w[NBITS_D-1:0]; alu_carry = diff_w[NBITS_D]; end
            OP_AND: alu_res = i_A & i_B;
            OP_OR:  alu_res = i_A | i_B;
            OP_XOR: alu_res = i_A ^ i_B;
            default: alu_res = i_A;
        endcase
    end

    // Next-state and next-output logic: accept work in IDLE/DONE, iterate in MUL_RUN.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        wr_acc_d = 1'b0;
        busy_d   = 1'b0;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            ST_MUL_RUN: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    result_d = mul_product[NBITS_D-1:0];
                    zero_d   = (mul_product[NBITS_D-1:0] == '0);
                    carry_d  = |mul_product[2*NBITS_D-1:NBITS_D];
                    wr_acc_d = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (i_start) begin
                    if (i_op == OP_MUL) begin
                        mul_load = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = ST_MUL_RUN;
                    end else if (i_op != OP_NOP) begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        carry_d  = alu_carry;
                        wr_acc_d = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
        endcase
    end

    // State and registered outputs; reset overrides any start in the same cycle.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (i_reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            wr_acc_q <= 1'b0;
            busy_q   <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            wr_acc_q <= wr_acc_d;
            busy_q   <= busy_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    assign o_result = result_q;
    assign o_WrAcc  = wr_acc_q;
    assign o_busy   = busy_q;
    assign o_zero   = zero_q;
    assign o_carry  = carry_q;

endmodule

// File: tb/tb_alu_seq_acc_feed.sv
// Directed bench for alu_seq_acc_feed with a result scoreboard checked on every strobe.
module tb_alu_seq_acc_feed;
    import alu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [2:0]  i_op = 3'b000;
    logic [15:0] i_A = 16'h0000;
    logic [15:0] i_B = 16'h0000;
    logic [15:0] o_result;
    logic        o_WrAcc;
    logic        o_busy;
    logic        o_zero;
    logic        o_carry;

    typedef struct packed {
        logic [15:0] res;
        logic        zero;
        logic        carry;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_strobe = 0;

    alu_seq_acc_feed dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_A      (i_A),
        .i_B      (i_B),
        .o_result (o_result),
        .o_WrAcc  (o_WrAcc),
        .o_busy   (o_busy),
        .o_zero   (o_zero),
        .o_carry  (o_carry)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour computed with wide arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] w;
        exp_t e;
        e.carry = 1'b0;
        case (op)
            OP_LDB: w = {16'h0000, b};
            OP_ADD: begin w = {16'h0000, a} + {16'h0000, b}; e.carry = w[16]; end
            OP_SUB: begin w = {16'h0000, a} - {16'h0000, b}; e.carry = (a < b); end
            OP_AND: w = {16'h0000, a & b};
            OP_OR:  w = {16'h0000, a | b};
            OP_XOR: w = {16'h0000, a ^ b};
            OP_MUL: begin w = {16'h0000, a} * {16'h0000, b}; e.carry = (w[31:16] != 16'h0000); end
            default: w = {16'h0000, a};
        endcase
        e.res  = w[15:0];
        e.zero = (e.res == 16'h0000);
        return e;
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        i_start = 1'b1;
        i_op    = op;
        i_A     = a;
        i_B     = b;
        if (op != OP_NOP) sb.push_back(model(op, a, b));
        step();
        i_start = 1'b0;
    endtask

    // Called in the cycle after a MUL launch; returns the strobe latency and busy-cycle count.
    task automatic mul_wait(input int inject_at, output int lat, output int busy_n);
        lat    = 1;
        busy_n = 0;
        while (o_WrAcc !== 1'b1 && lat < 40) begin
            if (o_busy === 1'b1) busy_n++;
            if (lat == inject_at) begin
                i_start = 1'b1;
                i_op    = OP_ADD;
                i_A     = 16'h0001;
                i_B     = 16'h0001;
            end
            step();
            i_start = 1'b0;
            lat++;
        end
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        if (!i_reset && o_WrAcc === 1'b1) begin
            exp_t e;
            n_strobe++;
            check("strobe_expected", {31'b0, sb.size() != 0}, 32'd1);
            check("strobe_busy_low", {31'b0, o_busy}, 32'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_result", {16'h0, o_result}, {16'h0, e.res});
                check("sb_zero",   {31'b0, o_zero},   {31'b0, e.zero});
                check("sb_carry",  {31'b0, o_carry},  {31'b0, e.carry});
            end
        end
    end

    initial begin
        int lat;
        int busy_n;
        int strobes_before;

        // 1: reset then idle
        repeat (2) step();
        i_reset = 1'b0;
        repeat (5) step();
        check("rst_result", {16'h0, o_result}, 32'h0);
        check("rst_wracc",  {31'b0, o_WrAcc},  32'd0);
        check("rst_busy",   {31'b0, o_busy},   32'd0);
        check("rst_zero",   {31'b0, o_zero},   32'd0);
        check("rst_carry",  {31'b0, o_carry},  32'd0);

        // 2: ADD wraps to zero with carry
        launch(OP_ADD, 16'hFFFF, 16'h0001);
        check("add_strobe", {31'b0, o_WrAcc}, 32'd1);
        check("add_result", {16'h0, o_result}, 32'h0000);
        step();
        check("add_strobe_one_cycle", {31'b0, o_WrAcc}, 32'd0);
        check("add_result_held", {16'h0, o_result}, 32'h0000);

        // 3: SUB borrow, then LDB back-to-back from DONE
        launch(OP_SUB, 16'h0003, 16'h0005);
        check("sub_strobe", {31'b0, o_WrAcc}, 32'd1);
        check("sub_result", {16'h0, o_result}, 32'hFFFE);
        launch(OP_LDB, 16'h0000, 16'h1234);
        check("ldb_b2b_strobe", {31'b0, o_WrAcc}, 32'd1);
        check("ldb_result", {16'h0, o_result}, 32'h1234);
        step();
        check("ldb_strobe_drop", {31'b0, o_WrAcc}, 32'd0);

        // Logic ops and a non-zero ADD
        launch(OP_AND, 16'hF0F0, 16'h3C3C);
        launch(OP_OR,  16'hF0F0, 16'h0C0C);
        launch(OP_XOR, 16'hAAAA, 16'hAAAA);
        launch(OP_ADD, 16'h1234, 16'h1111);
        step();

        // 4: MUL latency and results
        launch(OP_MUL, 16'h0012, 16'h0034);
        check("mul_busy_first", {31'b0, o_busy}, 32'd1);
        mul_wait(0, lat, busy_n);
        check("mul_latency", lat, 32'd17);
        check("mul_busy_cycles", busy_n, 32'd16);
        check("mul_result", {16'h0, o_result}, 32'h03A8);
        step();
        launch(OP_MUL, 16'h0100, 16'h0100);
        mul_wait(0, lat, busy_n);
        check("mul_ovf_latency", lat, 32'd17);
        check("mul_ovf_carry", {31'b0, o_carry}, 32'd1);
        step();
        launch(OP_MUL, 16'hFFFF, 16'hFFFF);
        mul_wait(0, lat, busy_n);
        check("mul_max_latency", lat, 32'd17);
        step();

        // 5: start during MUL_RUN is ignored, operand changes have no effect
        strobes_before = n_strobe;
        launch(OP_MUL, 16'h00FF, 16'h0003);
        mul_wait(4, lat, busy_n);
        check("mul_ignore_latency", lat, 32'd17);
        check("mul_ignore_result", {16'h0, o_result}, 32'h02FD);
        repeat (4) step();
        check("mul_ignore_single_strobe", n_strobe - strobes_before, 32'd1);

        // 6: reset mid-MUL aborts with no strobe
        strobes_before = n_strobe;
        launch(OP_MUL, 16'h1111, 16'h0002);
        repeat (7) step();
        check("abort_busy_before", {31'b0, o_busy}, 32'd1);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        sb.delete();
        check("abort_busy", {31'b0, o_busy}, 32'd0);
        check("abort_wracc", {31'b0, o_WrAcc}, 32'd0);
        check("abort_result", {16'h0, o_result}, 32'h0);
        repeat (20) step();
        check("abort_no_strobe", n_strobe - strobes_before, 32'd0);

        // NOP: no strobe, result held
        launch(OP_LDB, 16'h0000, 16'h00AA);
        step();
        strobes_before = n_strobe;
        launch(OP_NOP, 16'h5555, 16'h0000);
        check("nop_no_strobe", {31'b0, o_WrAcc}, 32'd0);
        check("nop_result_held", {16'h0, o_result}, 32'h00AA);
        repeat (3) step();
        check("nop_strobe_count", n_strobe - strobes_before, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
